// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage: opcode encodings, shifter control
// encodings, skid depth and the opcode decoder.
package shift_issue_stage_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    OP_SHLL  = 3'b000,
    OP_SHRL  = 3'b001,
    OP_SHRA  = 3'b010,
    OP_SHLLV = 3'b011,
    OP_SHRLV = 3'b100,
    OP_SHRAV = 3'b101
  } shift_op_e;

  typedef struct packed {
    logic right;
    logic arith;
    logic var_amt;
    logic illegal;
  } shift_ctl_t;

  function automatic shift_ctl_t decode_op(input logic [2:0] op);
    shift_ctl_t c;
    c = '0;
    c.right = DIR_LEFT;
    case (op)
      OP_SHLL:  c.right = DIR_LEFT;
      OP_SHRL:  c.right = DIR_RIGHT;
      OP_SHRA:  begin c.right = DIR_RIGHT; c.arith = 1'b1; end
      OP_SHLLV: c.var_amt = 1'b1;
      OP_SHRLV: begin c.right = DIR_RIGHT; c.var_amt = 1'b1; end
      OP_SHRAV: begin c.right = DIR_RIGHT; c.arith = 1'b1; c.var_amt = 1'b1; end
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shift_issue_stage_skid_buf.sv
// Two-entry result FIFO between the shifter and writeback; full flag is registered
// so the upstream ready never depends on the downstream ready.
module shift_skid_buf
  import shift_issue_stage_pkg::*;
#(
  parameter int unsigned DW = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data
);

  logic [DW-1:0] mem_q [SKID_DEPTH];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          full_q;
  logic          push;
  logic          pop;

  assign push_ready = !full_q;
  assign pop_valid  = (count_q != '0);
  assign pop_data   = mem_q[rd_ptr_q];
  assign push       = push_valid && !full_q;
  assign pop        = pop_valid && pop_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == 2'(SKID_DEPTH));
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= push_data;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift unit execute front end: decodes and registers operands (stage A), drives the
// external barrel shifter, and queues results in a 2-entry skid buffer.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [W-1:0]    in_rs_val,
  input  logic [W-1:0]    in_rt_val,
  input  logic [4:0]      in_shamt,
  input  logic [RD_W-1:0] in_rd,
  output logic [W-1:0]    sh_op1,
  output logic [W-1:0]    sh_op2,
  output logic            sh_dir,
  output logic            sh_arith,
  input  logic [W-1:0]    sh_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_zero,
  output logic            out_sign,
  output logic            out_err
);

  localparam int unsigned ENT_W = W + RD_W + 3;

  shift_ctl_t      ctl;
  logic            a_valid_q;
  logic            a_valid_d;
  logic [RD_W-1:0] a_rd_q;
  logic            a_err_q;
  logic [W-1:0]    op1_q;
  logic [W-1:0]    op2_q;
  logic            dir_q;
  logic            arith_q;
  logic            skid_ready;
  logic            accept;
  logic            advance;
  logic [W-1:0]    res_a;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] pop_data;

  assign ctl      = decode_op(in_op);
  assign in_ready = !a_valid_q || skid_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign advance  = a_valid_q && skid_ready;

  always_comb begin
    a_valid_d = a_valid_q;
    if (advance) a_valid_d = 1'b0;
    if (accept)  a_valid_d = 1'b1;
    if (flush)   a_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_rd_q    <= '0;
      a_err_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      dir_q     <= DIR_LEFT;
      arith_q   <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      if (accept) begin
        a_rd_q  <= in_rd;
        a_err_q <= ctl.illegal;
        op1_q   <= in_rt_val;
        op2_q   <= ctl.var_amt ? in_rs_val : {{(W-5){1'b0}}, in_shamt};
        dir_q   <= ctl.right;
        arith_q <= ctl.arith;
      end
    end
  end

  assign sh_op1   = op1_q;
  assign sh_op2   = op2_q;
  assign sh_dir   = dir_q;
  assign sh_arith = arith_q;

  // Illegal ops ignore the shifter entirely and force a zero result.
  assign res_a     = a_err_q ? '0 : sh_result;
  assign push_data = {res_a, a_rd_q, (res_a == '0), res_a[W-1], a_err_q};

  shift_skid_buf #(
    .DW(ENT_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (a_valid_q),
    .push_ready (skid_ready),
    .push_data  (push_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data)
  );

  assign {out_result, out_rd, out_zero, out_sign, out_err} = pop_data;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Randomized and directed bench for shift_issue_stage against a queue-based reference model.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] sh_op1, sh_op2, sh_result;
  logic        sh_dir, sh_arith;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_zero, out_sign, out_err;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q [$];
  logic signed [31:0] sh_s;
  bit acc;

  always #5 clk = ~clk;

  shift_issue_stage #(.W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_shamt(in_shamt),
    .in_rd(in_rd), .sh_op1(sh_op1), .sh_op2(sh_op2), .sh_dir(sh_dir), .sh_arith(sh_arith),
    .sh_result(sh_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_zero(out_zero), .out_sign(out_sign),
    .out_err(out_err)
  );

  // External saturating barrel shifter.
  always_comb begin
    sh_s = sh_op1;
    if (!sh_dir)       sh_result = sh_op1 << sh_op2;
    else if (sh_arith) sh_result = sh_s >>> sh_op2;
    else               sh_result = sh_op1 >> sh_op2;
  end

  function automatic logic [39:0] model(input logic [2:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [4:0] sa,
                                        input logic [4:0] rd);
    logic signed [31:0] srt;
    logic [31:0] r;
    logic err;
    srt = rt;
    err = 1'b0;
    case (op)
      3'd0: r = rt << sa;
      3'd1: r = rt >> sa;
      3'd2: r = srt >>> sa;
      3'd3: r = rt << rs;
      3'd4: r = rt >> rs;
      3'd5: r = srt >>> rs;
      default: begin r = '0; err = 1'b1; end
    endcase
    return {r, rd, (r == 32'd0), r[31], err};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs with the model, update the model, advance to the next negedge.
  task automatic cycle(output bit accepted);
    accepted = 1'b0;
    check("in_ready", in_ready, exp_q.size() < 3);
    if (exp_q.size() == 0) check("idle_out_valid", out_valid, 1'b0);
    if (exp_q.size() >= 2) check("busy_out_valid", out_valid, 1'b1);
    if (out_valid && exp_q.size() > 0)
      check("out_data", {out_result, out_rd, out_zero, out_sign, out_err}, exp_q[0]);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_rs_val, in_rt_val, in_shamt, in_rd));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sa, input logic [4:0] rd);
    in_op = op; in_rs_val = rs; in_rt_val = rt; in_shamt = sa; in_rd = rd;
  endtask

  task automatic send_one(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [4:0] sa, input logic [4:0] rd);
    bit a;
    a = 1'b0;
    drive(op, rs, rt, sa, rd);
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !a; n++) cycle(a);
    in_valid = 1'b0;
    if (!a) check("send_timeout", a, 1'b1);
  endtask

  task automatic drain(input int n);
    bit a;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) cycle(a);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int idx;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", {out_result, out_rd, out_zero, out_sign, out_err}, '0);
    check("rst_sh", {sh_op1, sh_op2, sh_dir, sh_arith}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: accept, then out_valid appears after the second edge.
    out_ready = 1'b1;
    drive(3'd0, 32'd0, 32'h0000_0001, 5'd4, 5'd3);
    in_valid = 1'b1;
    cycle(acc);
    check("lat_accept", acc, 1'b1);
    in_valid = 1'b0;
    check("lat_edge1", out_valid, 1'b0);
    cycle(acc);
    check("lat_edge2", out_valid, 1'b1);
    check("lat_result", out_result, 32'h0000_0010);
    drain(3);

    send_one(3'd5, 32'd40, 32'h8000_0000, 5'd0, 5'd7);
    cycle(acc);
    check("shrav_sat", {out_result, out_sign}, {32'hFFFF_FFFF, 1'b1});
    drain(3);
    send_one(3'd4, 32'd32, 32'hF000_0000, 5'd0, 5'd8);
    cycle(acc);
    check("shrlv_sat", {out_result, out_zero}, {32'h0, 1'b1});
    drain(3);

    // Stall: 5 back-to-back ops, out_ready low for 4 cycles.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      if (c == 4) out_ready = 1'b1;
      if (idx == 3 && c == 3) check("stall_in_ready", in_ready, 1'b0);
      drive(3'($urandom_range(0, 5)), $urandom, $urandom, 5'($urandom), 5'(idx));
      in_valid = 1'b1;
      cycle(acc);
      if (acc) idx++;
    end
    check("stall_sent", idx, 5);
    drain(6);

    send_one(3'd7, $urandom, 32'hDEAD_BEEF, 5'd3, 5'd9);
    cycle(acc);
    check("illegal", {out_result, out_err, out_zero, out_sign}, {32'h0, 1'b1, 1'b1, 1'b0});
    send_one(3'd1, 32'd0, 32'h8000_0000, 5'd31, 5'd10);
    drain(4);

    // Flush with 3 in flight; the offered op is dropped.
    out_ready = 1'b0;
    repeat (3) send_one(3'd2, $urandom, $urandom, 5'($urandom), 5'd11);
    drive(3'd0, 32'd0, 32'h1, 5'd1, 5'd12);
    in_valid = 1'b1;
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    send_one(3'd3, 32'd5, 32'h3, 5'd0, 5'd13);
    drain(4);

    for (int c = 0; c < 500; c++) begin
      drive(3'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom,
            $urandom, 5'($urandom), 5'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cycle(acc);
    end
    flush = 1'b0;
    drain(5);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    repeat (3) send_one(3'd1, $urandom, 32'hFFFF_FFFF, 5'd1, 5'd14);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_data", {out_result, out_rd, out_zero, out_sign, out_err}, '0);
    check("arst_sh", {sh_op1, sh_op2, sh_dir, sh_arith}, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_one(3'd0, 32'd0, 32'h0000_00F0, 5'd8, 5'd15);
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
